bnn_class_voter: RTL and testbench
==================================

# bnn_class_voter

Downstream stage of the 8-8-4 BNN core. It takes the registered 4-bit layer-2 neuron outputs and accumulates per-class vote counts over a fixed window of frames. At the end of each window it produces a registered winning class index and its vote count, and presents them on a valid/ready handshake to the host-facing output logic.

## Interface
Parameters:
- NUM_CLASSES, 4: number of layer-2 neurons (vote lanes).
- CNT_W, 4: width of the per-class and frame counters.
- WINDOW, 8: frames per decision. Legal range 1..2^CNT_W-1, so counters never overflow.

Ports:
- clk, input, 1: single clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- ena, input, 1: gates sample acceptance only. The handshake is unaffected by ena.
- class_bits, input, NUM_CLASSES: registered neuron outputs of layer 2. Bit i is a vote for class i.
- in_valid, input, 1: class_bits holds a new frame this cycle.
- clear, input, 1: synchronous restart of the current window.
- out_ready, input, 1: consumer accepts the result.
- out_valid, output, 1: a result is pending.
- out_class, output, clog2(NUM_CLASSES): winning class index.
- out_count, output, CNT_W: vote count of the winner.
- out_none, output, 1: no class received any vote in the window.
- overrun, output, 1: sticky. Set when a pending result was overwritten.
- overrun_clr, input, 1: clears overrun.

## Operation
- Sample accepted when in_valid && ena && !clear. For each i with class_bits[i]=1, cnt[i] += 1. frame_cnt += 1.
- Final sample: an accepted sample with frame_cnt == WINDOW-1. On that edge:
  - Compute argmax over the next-count values, including this final sample.
  - Load out_class, out_count and out_none into the result registers.
  - Set out_valid.
  - Clear all cnt[i] and frame_cnt to 0.
- Argmax rules:
  - Strict greater-than comparison; ties go to the lowest index.
  - All counts zero gives out_class=0, out_count=0, out_none=1.
- Handshake:
  - A transfer occurs when out_valid && out_ready.
  - out_valid drops on the edge after a transfer unless a new result loads on the same edge.
  - out_class, out_count and out_none hold stable while out_valid is high and no new result loads.
- Overwrite: a new result loading while out_valid=1 and out_ready=0 overwrites the result registers and sets overrun. The same event with out_ready=1 is a normal back-to-back transfer with no overrun.
- clear:
  - Zeroes cnt[] and frame_cnt.
  - Does not touch the result registers, out_valid or overrun.
  - clear together with in_valid: clear wins and the sample is dropped.
- overrun_clr together with a new overrun event: set wins.
- ena low: in_valid is ignored and the counters hold.
- Reset (asynchronous, any time):
  - cnt[], frame_cnt, out_valid, out_class, out_count, out_none and overrun all go to 0.
  - A partially accumulated window or a pending result is discarded.

## Timing
- Latency: out_valid is high starting one cycle after the edge that samples the final frame.
- Throughput: one sample per cycle. Back-to-back windows have no dead cycle.
- The argmax path is combinational from next-count to the result registers, within one cycle for NUM_CLASSES ≤ 8.
- All outputs are registered. No combinational path from any input to any output.
- WINDOW=1: every accepted sample produces a result.

## Structure
- Shared package bnn_pkg holds:
  - NUM_CLASSES and CLASS_W = clog2(NUM_CLASSES).
  - The default WINDOW and CNT_W.
- Sub-module bnn_argmax:
  - Purely combinational comparator tree over NUM_CLASSES counts.
  - Outputs index, max count and an all-zero flag.
  - Reused later for on-chip accuracy readout.
- Top level: counters, frame counter, result/valid registers and overrun flag.

## Test plan
All scenarios use WINDOW=8 unless stated.
- Reset: assert rst_n=0 mid-window with 5 frames counted, then release.
  - All outputs are 0.
  - Eight fresh 4'b0100 frames give out_class=2, out_count=8, with no contribution from the old 5 frames.
- Single winner: 8 frames of 4'b0010 with out_ready=1.
  - out_valid pulses exactly one cycle, on the cycle after the 8th sample.
  - out_class=1, out_count=8, out_none=0.
- Tie and no-vote:
  - 8 frames of 4'b1001 give out_class=0, out_count=8.
  - 8 frames of 4'b0000 give out_none=1, out_class=0, out_count=0.
- Backpressure and overrun:
  - Hold out_ready=0 for 16 frames: first window 4'b0001, second 4'b1000.
  - Result becomes out_class=3, out_count=8, overrun=1.
  - Pulse overrun_clr, then overrun=0.
- Back-to-back: 24 consecutive frames with out_ready=1 and alternating windows of 4'b0001 and 4'b0100.
  - Three results, classes 0, 2, 0, each exactly 8 cycles apart.
  - No overrun.
- clear and ena:
  - After 3 frames of 4'b0010, assert clear together with in_valid, then send 8 frames of 4'b0001 → out_class=0, out_count=8.
  - Frames presented with ena=0 do not advance frame_cnt.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared constants for the 8-8-4 BNN core and its downstream stages.
package bnn_pkg;

    localparam int NUM_CLASSES = 4;
    localparam int CLASS_W     = $clog2(NUM_CLASSES);
    localparam int CNT_W       = 4;
    localparam int WINDOW      = 8;

endpackage

// File: rtl/bnn_argmax.sv
// Combinational argmax over N packed counts. Strict greater-than keeps the
// lowest index on ties. Also used for on-chip accuracy readout.
module bnn_argmax #(
    parameter int N     = bnn_pkg::NUM_CLASSES,
    parameter int CNT_W = bnn_pkg::CNT_W
) (
    input  logic [N*CNT_W-1:0]   counts,
    output logic [$clog2(N)-1:0] max_idx,
    output logic [CNT_W-1:0]     max_cnt,
    output logic                 all_zero
);

    localparam int IDX_W = $clog2(N);

    // Priority scan: a later lane replaces the best only when strictly larger.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        max_idx = '0;
        max_cnt = counts[CNT_W-1:0];
        for (int i = 1; i < N; i++) begin
            if (counts[i*CNT_W +: CNT_W] > max_cnt) begin
                max_cnt = counts[i*CNT_W +: CNT_W];
                max_idx = IDX_W'(i);
            end
        end
        all_zero = (max_cnt == '0);
    end

endmodule

// File: rtl/bnn_class_voter.sv
// Per-class vote accumulator over a fixed frame window. At the end of each
// window the argmax of the counts is registered and offered on valid/ready.
module bnn_class_voter #(
    parameter int NUM_CLASSES = bnn_pkg::NUM_CLASSES,
    parameter int CNT_W       = bnn_pkg::CNT_W,
    parameter int WINDOW      = bnn_pkg::WINDOW
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ena,
    input  logic [NUM_CLASSES-1:0]         class_bits,
    input  logic                           in_valid,
    input  logic                           clear,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [$clog2(NUM_CLASSES)-1:0] out_class,
    output logic [CNT_W-1:0]               out_count,
    output logic                           out_none,
    output logic                           overrun,
    input  logic                           overrun_clr
);

    localparam int CLASS_W = $clog2(NUM_CLASSES);

    logic [CNT_W-1:0]             cnt [NUM_CLASSES];
    logic [CNT_W-1:0]             frame_cnt;
    logic [NUM_CLASSES*CNT_W-1:0] cnt_next;
    logic                         accept;
    logic                         final_sample;
    logic [CLASS_W-1:0]           win_class;
    logic [CNT_W-1:0]             win_count;
    logic                         win_none;

    // clear beats a simultaneous sample; ena only gates acceptance.
    assign accept       = in_valid && ena && !clear;
    assign final_sample = accept && (frame_cnt == CNT_W'(WINDOW - 1));

    // Next-count values, including the sample presented this cycle.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            cnt_next[i*CNT_W +: CNT_W] = cnt[i] + CNT_W'(accept && class_bits[i]);
        end
    end

    bnn_argmax #(
        .N     (NUM_CLASSES),
        .CNT_W (CNT_W)
    ) u_argmax (
        .counts   (cnt_next),
        .max_idx  (win_class),
        .max_cnt  (win_count),
        .all_zero (win_none)
    );

    // Vote and frame counters: restart on clear or after the final sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the count array is a few flops, not a RAM, so it is reset
            // with everything else; a partial window must not survive reset.
            for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
            frame_cnt <= '0;
        end else if (clear || final_sample) begin
            for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
            frame_cnt <= '0;
        end else if (accept) begin
            // NOTE: non-blocking so every counter updates from pre-edge values.
            for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= cnt_next[i*CNT_W +: CNT_W];
            frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

    // Result registers, valid handshake and sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_class <= '0;
            out_count <= '0;
            out_none  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (final_sample) begin
                out_valid <= 1'b1;
                out_class <= win_class;
                out_count <= win_count;
                out_none  <= win_none;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // A load over an unaccepted result is an overrun; set beats clear.
            if (final_sample && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bnn_class_voter.sv
// Self-checking bench for bnn_class_voter (NUM_CLASSES=4, CNT_W=4, WINDOW=8).
module tb_bnn_class_voter;

    localparam int WINDOW = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [3:0] class_bits;
    logic       in_valid;
    logic       clear;
    logic       out_ready;
    logic       out_valid;
    logic [1:0] out_class;
    logic [3:0] out_count;
    logic       out_none;
    logic       overrun;
    logic       overrun_clr;
    logic [8:0] obs;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: what the result port should show after each edge.
    int m_votes [4];
    int m_frames;
    bit m_valid;
    int m_class;
    int m_count;
    bit m_none;
    bit m_overrun;

    always #5 clk = ~clk;

    assign obs = {out_valid, out_class, out_count, out_none, overrun};

    bnn_class_voter #(
        .NUM_CLASSES (4),
        .CNT_W       (4),
        .WINDOW      (WINDOW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .class_bits  (class_bits),
        .in_valid    (in_valid),
        .clear       (clear),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_class   (out_class),
        .out_count   (out_count),
        .out_none    (out_none),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    function automatic logic [8:0] exp_vec();
        return {m_valid, 2'(m_class), 4'(m_count), m_none, m_overrun};
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) m_votes[c] = 0;
        m_frames  = 0;
        m_valid   = 0;
        m_class   = 0;
        m_count   = 0;
        m_none    = 0;
        m_overrun = 0;
    endfunction

    // One clock edge of the specified behaviour, from the pre-edge state.
    function automatic void model_step(input logic [3:0] bits, input logic iv,
                                       input logic en, input logic clr,
                                       input logic rdy, input logic oc);
        bit load      = 0;
        bit old_valid = m_valid;
        int mx        = 0;
        int win       = -1;
        if (clr) begin
            for (int c = 0; c < 4; c++) m_votes[c] = 0;
            m_frames = 0;
        end else if (iv && en) begin
            for (int c = 0; c < 4; c++) if (bits[c]) m_votes[c]++;
            m_frames++;
            if (m_frames == WINDOW) begin
                for (int c = 0; c < 4; c++) if (m_votes[c] > mx) mx = m_votes[c];
                for (int c = 3; c >= 0; c--) if (m_votes[c] == mx) win = c;
                m_class = win;
                m_count = mx;
                m_none  = (mx == 0);
                load    = 1;
                for (int c = 0; c < 4; c++) m_votes[c] = 0;
                m_frames = 0;
            end
        end
        if (load && old_valid && !rdy) m_overrun = 1;
        else if (oc) m_overrun = 0;
        if (load) m_valid = 1;
        else if (old_valid && rdy) m_valid = 0;
    endfunction

    // Drive one cycle of inputs, advance the model with the edge, sample at +1.
    task automatic step(input logic [3:0] bits, input logic iv, input logic en,
                        input logic clr, input logic rdy, input logic oc);
        class_bits  = bits;
        in_valid    = iv;
        ena         = en;
        clear       = clr;
        out_ready   = rdy;
        overrun_clr = oc;
        @(posedge clk);
        model_step(bits, iv, en, clr, rdy, oc);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        checks++;
        if (obs !== 9'b0) begin
            errors++;
            $display("FAIL reset_initial: got %b want %b", obs, 9'b0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) step(4'($urandom_range(15)), 1, 1, 0, 1, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs !== 9'b0) begin
            errors++;
            $display("FAIL reset_mid_window: got %b want %b", obs, 9'b0);
        end
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(4'b0100, 1, 1, 0, 0, 0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL reset_refill step %0d: got %b want %b", cyc, obs, exp_vec());
            end
        end
        checks++;
        if ({out_valid, out_class, out_count, out_none} !== {1'b1, 2'd2, 4'd8, 1'b0}) begin
            errors++;
            $display("FAIL reset_result: got v=%0b c=%0d n=%0d z=%0b want v=1 c=2 n=8 z=0",
                     out_valid, out_class, out_count, out_none);
        end
        step(4'b0000, 0, 1, 0, 1, 0);
    endtask

    task automatic test_single_winner();
        for (int k = 0; k < 8; k++) begin
            step(4'b0010, 1, 1, 0, 1, 0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL single step %0d: got %b want %b", cyc, obs, exp_vec());
            end
        end
        checks++;
        if ({out_valid, out_class, out_count, out_none} !== {1'b1, 2'd1, 4'd8, 1'b0}) begin
            errors++;
            $display("FAIL single_result: got v=%0b c=%0d n=%0d z=%0b want v=1 c=1 n=8 z=0",
                     out_valid, out_class, out_count, out_none);
        end
        step(4'b0000, 0, 1, 0, 1, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_width: got out_valid=%0b want 0", out_valid);
        end
    endtask

    task automatic test_tie_none();
        for (int k = 0; k < 8; k++) step(4'b1001, 1, 1, 0, 1, 0);
        checks++;
        if ({out_valid, out_class, out_count, out_none} !== {1'b1, 2'd0, 4'd8, 1'b0}) begin
            errors++;
            $display("FAIL tie_result: got v=%0b c=%0d n=%0d z=%0b want v=1 c=0 n=8 z=0",
                     out_valid, out_class, out_count, out_none);
        end
        for (int k = 0; k < 8; k++) step(4'b0000, 1, 1, 0, 1, 0);
        checks++;
        if ({out_valid, out_class, out_count, out_none} !== {1'b1, 2'd0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL none_result: got v=%0b c=%0d n=%0d z=%0b want v=1 c=0 n=0 z=1",
                     out_valid, out_class, out_count, out_none);
        end
        step(4'b0000, 0, 1, 0, 1, 0);
    endtask

    task automatic test_overrun();
        for (int k = 0; k < 16; k++) begin
            step((k < 8) ? 4'b0001 : 4'b1000, 1, 1, 0, 0, 0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL overrun step %0d: got %b want %b", cyc, obs, exp_vec());
            end
        end
        checks++;
        if ({out_valid, out_class, out_count, overrun} !== {1'b1, 2'd3, 4'd8, 1'b1}) begin
            errors++;
            $display("FAIL overrun_result: got v=%0b c=%0d n=%0d ovr=%0b want v=1 c=3 n=8 ovr=1",
                     out_valid, out_class, out_count, overrun);
        end
        step(4'b0000, 0, 1, 0, 0, 1);
        checks++;
        if ({out_valid, overrun} !== 2'b10) begin
            errors++;
            $display("FAIL overrun_clr: got v=%0b ovr=%0b want v=1 ovr=0", out_valid, overrun);
        end
        step(4'b0000, 0, 1, 0, 1, 0);
    endtask

    task automatic test_back_to_back();
        int exp_cls [3] = '{0, 2, 0};
        int hits        = 0;
        int last_hit    = -1;
        for (int s = 0; s < 24; s++) begin
            step(((s / 8) % 2 == 0) ? 4'b0001 : 4'b0100, 1, 1, 0, 1, 0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL b2b step %0d: got %b want %b", cyc, obs, exp_vec());
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (hits >= 3 || out_class !== 2'(exp_cls[hits]) || s != 8 * hits + 7) begin
                    errors++;
                    $display("FAIL b2b_result %0d: got class %0d at frame %0d want class %0d at frame %0d",
                             hits, out_class, s, (hits < 3) ? exp_cls[hits] : -1, 8 * hits + 7);
                end
                if (last_hit >= 0) begin
                    checks++;
                    if (s - last_hit != 8) begin
                        errors++;
                        $display("FAIL b2b_spacing: got %0d cycles want 8", s - last_hit);
                    end
                end
                hits++;
                last_hit = s;
            end
        end
        checks++;
        if (hits != 3 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_summary: got %0d results ovr=%0b want 3 results ovr=0", hits, overrun);
        end
        step(4'b0000, 0, 1, 0, 1, 0);
    endtask

    task automatic test_clear_ena();
        for (int k = 0; k < 3; k++) step(4'b0010, 1, 1, 0, 1, 0);
        step(4'b0010, 1, 1, 1, 1, 0);
        for (int k = 0; k < 8; k++) begin
            step(4'b0001, 1, 1, 0, 1, 0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL clear step %0d: got %b want %b", cyc, obs, exp_vec());
            end
        end
        checks++;
        if ({out_valid, out_class, out_count} !== {1'b1, 2'd0, 4'd8}) begin
            errors++;
            $display("FAIL clear_result: got v=%0b c=%0d n=%0d want v=1 c=0 n=8",
                     out_valid, out_class, out_count);
        end
        step(4'b0000, 0, 1, 0, 1, 0);
        for (int k = 0; k < 3; k++) step(4'($urandom_range(15)), 1, 1, 0, 1, 0);
        for (int k = 0; k < 10; k++) begin
            step(4'($urandom_range(15)), 1, 0, 0, 1, 0);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL ena_hold step %0d: got out_valid=%0b want 0", cyc, out_valid);
            end
        end
        for (int k = 0; k < 5; k++) begin
            step(4'($urandom_range(15)), 1, 1, 0, 1, 0);
            checks++;
            if (out_valid !== ((k == 4) ? 1'b1 : 1'b0) || obs !== exp_vec()) begin
                errors++;
                $display("FAIL ena_resume step %0d: got %b want %b", cyc, obs, exp_vec());
            end
        end
        step(4'b0000, 0, 1, 0, 1, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step(4'($urandom_range(15)),
                 $urandom_range(99) < 75,
                 $urandom_range(99) < 85,
                 $urandom_range(99) < 5,
                 $urandom_range(99) < 60,
                 $urandom_range(99) < 10);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random step %0d: got %b want %b", cyc, obs, exp_vec());
            end
        end
    endtask

    initial begin
        ena         = 1'b0;
        class_bits  = 4'b0000;
        in_valid    = 1'b0;
        clear       = 1'b0;
        out_ready   = 1'b0;
        overrun_clr = 1'b0;
        test_reset();
        test_single_winner();
        test_tie_none();
        test_overrun();
        test_back_to_back();
        test_clear_ena();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
